// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: data width, byte-lane
// mask encodings, port identifiers and the lane/alignment legality rule.
package dmem_port_arbiter_pkg;

  localparam int DMEM_XLEN = 32;

  localparam logic [3:0] AMP_W  = 4'b1111;
  localparam logic [3:0] AMP_H0 = 4'b0011;
  localparam logic [3:0] AMP_H1 = 4'b1100;
  localparam logic [3:0] AMP_B0 = 4'b0001;
  localparam logic [3:0] AMP_B1 = 4'b0010;
  localparam logic [3:0] AMP_B2 = 4'b0100;
  localparam logic [3:0] AMP_B3 = 4'b1000;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  // A lane mask is legal only if it is one of the listed encodings and its
  // lowest enabled byte matches the low address bits.
  function automatic logic amp_legal(input logic [3:0] amp, input logic [1:0] addr_lsb);
    logic ok;
    ok = 1'b0;
    case (amp)
      AMP_W, AMP_H0, AMP_B0: ok = (addr_lsb == 2'b00);
      AMP_B1:                ok = (addr_lsb == 2'b01);
      AMP_H1, AMP_B2:        ok = (addr_lsb == 2'b10);
      AMP_B3:                ok = (addr_lsb == 2'b11);
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_amp_check.sv
// Combinational byte-lane legality check for one requester port.
module dmem_amp_check
  import dmem_port_arbiter_pkg::*;
(
  input  logic [3:0] amp,
  input  logic [1:0] addr_lsb,
  output logic       legal
);

  assign legal = amp_legal(amp, addr_lsb);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port dmem between the core LSU
// (port 0) and the loader/debug DMA (port 1), with a burst cap under
// contention, lane legality checking and registered read-data return.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int XLEN      = DMEM_XLEN,
  parameter int BURST_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [3:0]      p0_amp,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [XLEN-1:0] p0_rdata,
  output logic            p0_err,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [3:0]      p1_amp,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [XLEN-1:0] p1_rdata,
  output logic            p1_err,
  output logic            mem_we,
  output logic [3:0]      mem_amp,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  port_t         last_gnt;
  logic [CW-1:0] burst_cnt;
  logic          legal0;
  logic          legal1;
  logic          gnt0;
  logic          gnt1;
  logic          keep_last;

  dmem_amp_check u_chk0 (
    .amp      (p0_amp),
    .addr_lsb (p0_addr[1:0]),
    .legal    (legal0)
  );

  dmem_amp_check u_chk1 (
    .amp      (p1_amp),
    .addr_lsb (p1_addr[1:0]),
    .legal    (legal1)
  );

  // A zero burst count only occurs after reset and means no burst is open,
  // so the first contended grant switches away from last_gnt (port 0 wins).
  assign keep_last = (burst_cnt != '0) && (burst_cnt < CNT_MAX);

  // Grant decision: a lone requester always wins; under contention the
  // current owner keeps the port until its burst reaches the cap.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (p0_req && p1_req) begin
      if (keep_last) begin
        gnt0 = (last_gnt == PORT0);
        gnt1 = (last_gnt == PORT1);
      end else begin
        gnt0 = (last_gnt == PORT1);
        gnt1 = (last_gnt == PORT0);
      end
    end else begin
      gnt0 = p0_req;
      gnt1 = p1_req;
    end
  end

  assign p0_gnt  = gnt0;
  assign p1_gnt  = gnt1;

  assign mem_amp = gnt1 ? p1_amp   : p0_amp;
  assign mem_a   = gnt1 ? p1_addr  : p0_addr;
  assign mem_wd  = gnt1 ? p1_wdata : p0_wdata;
  assign mem_we  = gnt1 ? (p1_we & legal1) : (gnt0 & p0_we & legal0);

  // Arbitration history: remember the last owner and how long it has held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt  <= PORT1;
      burst_cnt <= '0;
    end else if (gnt0 || gnt1) begin
      if ((gnt1 ? PORT1 : PORT0) == last_gnt) begin
        if (burst_cnt < CNT_MAX) begin
          burst_cnt <= burst_cnt + CW'(1);
        end
      end else begin
        burst_cnt <= CW'(1);
      end
      last_gnt <= gnt1 ? PORT1 : PORT0;
    end
  end

  // Port 0 return: pulse one cycle after grant, data only for legal loads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
    end else begin
      p0_rvalid <= gnt0;
      p0_err    <= gnt0 & ~legal0;
      p0_rdata  <= (gnt0 && !p0_we && legal0) ? mem_rd : '0;
    end
  end

  // Port 1 return: same timing and data rules as port 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p1_rvalid <= gnt1;
      p1_err    <= gnt1 & ~legal1;
      p1_rdata  <= (gnt1 && !p1_we && legal1) ? mem_rd : '0;
    end
  end

endmodule
